// File: rtl/coord_request_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | coord_request_queue_if: pop handshake between queue and cell worker  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface coord_request_queue_if;
  logic        rtc_read;
  logic        rtc_poll_ready;
  logic [16:0] idx_out;
  logic [63:0] x0_out;
  logic [63:0] y0_out;

  modport master (
    input  rtc_read,
    output rtc_poll_ready,
    output idx_out,
    output x0_out,
    output y0_out
  );

  modport slave (
    output rtc_read,
    input  rtc_poll_ready,
    input  idx_out,
    input  x0_out,
    input  y0_out
  );
endinterface
`default_nettype wire

// File: rtl/coord_request_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | coord_request_queue: raster walk of one frame, per-pixel (x0,y0)     |
// | start points buffered in a FIFO for the cell worker. Rev 1.0         |
// +----------------------------------------------------------------------+
module coord_request_queue #(
  parameter int FRAME_W    = 320,
  parameter int FRAME_H    = 240,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [63:0]           x_min_in,
  input  logic [63:0]           y_max_in,
  input  logic [63:0]           step_in,
  coord_request_queue_if.master rtc,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int                 c_ptr_w      = $clog2(FIFO_DEPTH);
  localparam int                 c_entry_w    = 17 + 64 + 64;
  localparam logic [16:0]        c_last_idx   = 17'(FRAME_W * FRAME_H - 1);
  localparam logic [16:0]        c_last_col   = 17'(FRAME_W - 1);
  localparam logic [c_ptr_w:0]   c_count_full = (c_ptr_w + 1)'(FIFO_DEPTH);
  localparam logic [c_ptr_w:0]   c_count_one  = (c_ptr_w + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GEN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  logic [63:0]          r_x_min;
  logic [63:0]          r_step;
  logic [16:0]          r_col;
  logic [16:0]          r_idx;
  logic [63:0]          r_x_acc;
  logic [63:0]          r_y_acc;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w:0]     r_count;
  logic                 r_ready;
  logic [16:0]          r_idx_out;
  logic [63:0]          r_x0_out;
  logic [63:0]          r_y0_out;
  logic                 r_busy;
  logic                 r_frame_done;
  logic [c_entry_w-1:0] r_mem [FIFO_DEPTH];

  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic [c_ptr_w:0]     w_count_next;
  logic [c_entry_w-1:0] w_head;

  // A start pulse flushes the FIFO, so neither a pop nor a push may land in that cycle.
  assign w_full = (r_count == c_count_full);
  assign w_pop  = rtc.rtc_read && r_ready && !start;
  assign w_push = (r_state == S_GEN) && !start && (!w_full || w_pop);
  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_idx, r_x_acc, r_y_acc};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_x_min      <= '0;
      r_step       <= '0;
      r_col        <= '0;
      r_idx        <= '0;
      r_x_acc      <= '0;
      r_y_acc      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_ready      <= 1'b0;
      r_idx_out    <= 17'h1FFFF;
      r_x0_out     <= '0;
      r_y0_out     <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (start) begin
        r_state  <= S_GEN;
        r_busy   <= 1'b1;
        r_x_min  <= x_min_in;
        r_step   <= step_in;
        r_col    <= '0;
        r_idx    <= '0;
        r_x_acc  <= x_min_in;
        r_y_acc  <= y_max_in;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_ready  <= 1'b0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_idx    <= r_idx + 1'b1;
          if (r_col == c_last_col) begin
            r_col   <= '0;
            r_x_acc <= r_x_min;
            r_y_acc <= r_y_acc - r_step;
          end else begin
            r_col   <= r_col + 1'b1;
            r_x_acc <= r_x_acc + r_step;
          end
          if (r_idx == c_last_idx) begin
            r_state <= S_DRAIN;
          end
        end
        if (w_pop) begin
          r_rd_ptr                           <= r_rd_ptr + 1'b1;
          {r_idx_out, r_x0_out, r_y0_out}    <= w_head;
        end
        r_count <= w_count_next;
        r_ready <= (w_count_next != '0);
        // In DRAIN the last remaining entry is always the final pixel.
        if ((r_state == S_DRAIN) && w_pop && (r_count == c_count_one)) begin
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
          r_frame_done <= 1'b1;
        end
      end
    end
  end

  assign rtc.rtc_poll_ready = r_ready;
  assign rtc.idx_out        = r_idx_out;
  assign rtc.x0_out         = r_x0_out;
  assign rtc.y0_out         = r_y0_out;
  assign busy               = r_busy;
  assign frame_done         = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_coord_request_queue.sv
`default_nettype none
// Randomised scoreboard bench for coord_request_queue: two instances (4x3 frame, 2x2 wrap frame).
`timescale 1ns/1ps
module tb_coord_request_queue;

  localparam int AW = 4, AH = 3, AD = 4;
  localparam int BW = 2, BH = 2, BD = 2;
  localparam logic [16:0] LAST_A = 17'(AW * AH - 1);
  localparam logic [16:0] LAST_B = 17'(BW * BH - 1);

  typedef struct {
    logic [16:0] idx;
    logic [63:0] x;
    logic [63:0] y;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [63:0] xm_a = '0, ym_a = '0, st_a = '0;
  logic [63:0] xm_b = '0, ym_b = '0, st_b = '0;
  logic        busy_a, done_a, busy_b, done_b;

  coord_request_queue_if bus_a();
  coord_request_queue_if bus_b();

  coord_request_queue #(.FRAME_W(AW), .FRAME_H(AH), .FIFO_DEPTH(AD)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a),
    .x_min_in(xm_a), .y_max_in(ym_a), .step_in(st_a),
    .rtc(bus_a.master), .busy(busy_a), .frame_done(done_a)
  );

  coord_request_queue #(.FRAME_W(BW), .FRAME_H(BH), .FIFO_DEPTH(BD)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b),
    .x_min_in(xm_b), .y_max_in(ym_b), .step_in(st_b),
    .rtc(bus_b.master), .busy(busy_b), .frame_done(done_b)
  );

  always #5 clock = ~clock;

  int   checks = 0, failures = 0;
  exp_t qa[$], qb[$];
  logic [63:0] got_x_a [AW*AH], got_y_a [AW*AH];
  logic [63:0] got_x_b [BW*BH], got_y_b [BW*BH];
  int   done_cnt_a = 0, done_cnt_b = 0, exp_done_a = 0;
  int   rd_mode_a = 0;
  int   cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: pixel i sits at column i%w, row i/w of a uniform grid.
  function automatic exp_t model(input int w, input int i, input logic [63:0] xm,
                                 input logic [63:0] ym, input logic [63:0] st);
    exp_t e;
    e.idx = 17'(i);
    e.x   = xm + 64'(i % w) * st;
    e.y   = ym - 64'(i / w) * st;
    return e;
  endfunction

  // Read drivers
  initial begin
    bus_a.rtc_read = 1'b0;
    bus_b.rtc_read = 1'b0;
    forever begin
      @(posedge clock); #1;
      cyc++;
      case (rd_mode_a)
        0:       bus_a.rtc_read = 1'b0;
        1:       bus_a.rtc_read = 1'b1;
        2:       bus_a.rtc_read = (cyc % 3 == 0);
        default: bus_a.rtc_read = 1'($urandom_range(0, 1));
      endcase
      bus_b.rtc_read = 1'b1;
    end
  end

  // Monitor A
  logic pend_a = 1'b0, exp_busy_a = 1'b0, start_seen_a = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      pend_a = 1'b0; exp_busy_a = 1'b0; start_seen_a = 1'b0;
    end else begin
      if (start_seen_a) exp_busy_a = 1'b1;
      if (pend_a) begin
        if (qa.size() == 0) begin
          check("a_unexpected_pop", 64'(bus_a.idx_out), 64'h1FFFF);
        end else begin
          e = qa.pop_front();
          check("a_idx", 64'(bus_a.idx_out), 64'(e.idx));
          check("a_x0", bus_a.x0_out, e.x);
          check("a_y0", bus_a.y0_out, e.y);
          check("a_frame_done", 64'(done_a), 64'(e.idx == LAST_A));
          got_x_a[int'(e.idx)] = bus_a.x0_out;
          got_y_a[int'(e.idx)] = bus_a.y0_out;
          if (e.idx == LAST_A) exp_busy_a = 1'b0;
        end
      end else begin
        check("a_frame_done_idle", 64'(done_a), 64'd0);
      end
      check("a_busy", 64'(busy_a), 64'(exp_busy_a));
      if (done_a) done_cnt_a++;
      start_seen_a = start_a;
      pend_a = bus_a.rtc_read && bus_a.rtc_poll_ready && !start_a;
    end
  end

  // Monitor B
  logic pend_b = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      pend_b = 1'b0;
    end else begin
      if (pend_b) begin
        if (qb.size() == 0) begin
          check("b_unexpected_pop", 64'(bus_b.idx_out), 64'h1FFFF);
        end else begin
          e = qb.pop_front();
          check("b_idx", 64'(bus_b.idx_out), 64'(e.idx));
          check("b_x0", bus_b.x0_out, e.x);
          check("b_y0", bus_b.y0_out, e.y);
          check("b_frame_done", 64'(done_b), 64'(e.idx == LAST_B));
          got_x_b[int'(e.idx)] = bus_b.x0_out;
          got_y_b[int'(e.idx)] = bus_b.y0_out;
        end
      end
      if (done_b) done_cnt_b++;
      pend_b = bus_b.rtc_read && bus_b.rtc_poll_ready && !start_b;
    end
  end

  task automatic start_a_frame(input logic [63:0] xm, input logic [63:0] ym, input logic [63:0] st);
    @(posedge clock); #1;
    start_a = 1'b1; xm_a = xm; ym_a = ym; st_a = st;
    @(negedge clock); #1;
    qa.delete();
    for (int i = 0; i < AW * AH; i++) qa.push_back(model(AW, i, xm, ym, st));
    @(posedge clock); #1;
    start_a = 1'b0;
  endtask

  task automatic start_b_frame(input logic [63:0] xm, input logic [63:0] ym, input logic [63:0] st);
    @(posedge clock); #1;
    start_b = 1'b1; xm_b = xm; ym_b = ym; st_b = st;
    @(negedge clock); #1;
    qb.delete();
    for (int i = 0; i < BW * BH; i++) qb.push_back(model(BW, i, xm, ym, st));
    @(posedge clock); #1;
    start_b = 1'b0;
  endtask

  task automatic wait_idle(input bit use_b, input string name);
    int n = 0;
    while (n < 400 && (use_b ? (qb.size() != 0 || busy_b) : (qa.size() != 0 || busy_a))) begin
      @(negedge clock); #2;
      n++;
    end
    check({name, "_drain_timeout"}, 64'(n < 400), 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_a_ready"}, 64'(bus_a.rtc_poll_ready), 64'd0);
    check({tag, "_a_idx"},   64'(bus_a.idx_out), 64'h1FFFF);
    check({tag, "_a_x0"},    bus_a.x0_out, 64'd0);
    check({tag, "_a_y0"},    bus_a.y0_out, 64'd0);
    check({tag, "_a_busy"},  64'(busy_a), 64'd0);
    check({tag, "_a_done"},  64'(done_a), 64'd0);
    check({tag, "_b_idx"},   64'(bus_b.idx_out), 64'h1FFFF);
    check({tag, "_b_busy"},  64'(busy_b), 64'd0);
  endtask

  initial begin
    logic [63:0] rx, ry, rs;
    // Reset, with reads requested on an empty queue
    rd_mode_a = 1;
    repeat (3) @(negedge clock);
    check_reset_vals("rst");
    @(posedge clock); #1; reset_n = 1'b1;
    repeat (6) @(negedge clock);
    check("empty_read_ready", 64'(bus_a.rtc_poll_ready), 64'd0);
    check("empty_read_idx", 64'(bus_a.idx_out), 64'h1FFFF);

    // Directed frame, reads always high
    start_a_frame(64'(-8), 64'd6, 64'd2);
    wait_idle(1'b0, "frame1");
    exp_done_a++;
    check("frame1_done_cnt", 64'(done_cnt_a), 64'(exp_done_a));
    check("f1_x0_idx0",  got_x_a[0],  64'(-8));
    check("f1_y0_idx0",  got_y_a[0],  64'd6);
    check("f1_x0_idx3",  got_x_a[3],  64'(-2));
    check("f1_y0_idx3",  got_y_a[3],  64'd6);
    check("f1_x0_idx4",  got_x_a[4],  64'(-8));
    check("f1_y0_idx4",  got_y_a[4],  64'd4);
    check("f1_x0_idx11", got_x_a[11], 64'(-2));
    check("f1_y0_idx11", got_y_a[11], 64'd2);
    check("f1_ready_after", 64'(bus_a.rtc_poll_ready), 64'd0);

    // Same frame with reads held off: generator must stall, outputs hold
    rd_mode_a = 0;
    start_a_frame(64'(-8), 64'd6, 64'd2);
    repeat (30) @(negedge clock);
    #2;
    check("stall_ready", 64'(bus_a.rtc_poll_ready), 64'd1);
    check("stall_busy", 64'(busy_a), 64'd1);
    check("stall_idx_hold", 64'(bus_a.idx_out), 64'd11);
    check("stall_x0_hold", bus_a.x0_out, 64'(-2));
    rd_mode_a = 2;
    wait_idle(1'b0, "stall");
    exp_done_a++;
    check("stall_done_cnt", 64'(done_cnt_a), 64'(exp_done_a));

    // Restart mid-frame with x_min=0
    rd_mode_a = 1;
    start_a_frame(64'd100, 64'd50, 64'd3);
    repeat (6) @(negedge clock);
    start_a_frame(64'd0, 64'd9, 64'd1);
    wait_idle(1'b0, "restart");
    exp_done_a++;
    check("restart_done_cnt", 64'(done_cnt_a), 64'(exp_done_a));
    check("restart_x0_idx0", got_x_a[0], 64'd0);
    check("restart_x0_idx5", got_x_a[5], 64'd1);

    // Asynchronous reset mid-frame
    start_a_frame(64'd5, 64'd5, 64'd5);
    repeat (5) @(negedge clock);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    qa.delete(); qb.delete();
    repeat (2) @(negedge clock);
    @(posedge clock); #1; reset_n = 1'b1;
    start_a_frame(64'(-8), 64'd6, 64'd2);
    wait_idle(1'b0, "postrst");
    exp_done_a++;
    check("postrst_done_cnt", 64'(done_cnt_a), 64'(exp_done_a));
    check("postrst_x0_idx0", got_x_a[0], 64'(-8));
    check("postrst_y0_idx11", got_y_a[11], 64'd2);

    // Wraparound on the 2-wide instance
    start_b_frame(64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'd1);
    wait_idle(1'b1, "wrap");
    check("wrap_x0_col0", got_x_b[0], 64'h7FFF_FFFF_FFFF_FFFF);
    check("wrap_x0_col1", got_x_b[1], 64'h8000_0000_0000_0000);
    check("wrap_y0_row1", got_y_b[2], 64'hFFFF_FFFF_FFFF_FFFF);
    check("wrap_done_cnt", 64'(done_cnt_b), 64'd1);

    // Randomised frames, random read patterns, occasional restarts
    for (int f = 0; f < 8; f++) begin
      rd_mode_a = $urandom_range(1, 3);
      rx = {$urandom, $urandom}; ry = {$urandom, $urandom}; rs = {$urandom, $urandom};
      start_a_frame(rx, ry, rs);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(2, 15)) @(negedge clock);
        rx = {$urandom, $urandom}; ry = {$urandom, $urandom}; rs = {$urandom, $urandom};
        start_a_frame(rx, ry, rs);
      end
      wait_idle(1'b0, "rand");
      exp_done_a++;
      check("rand_done_cnt", 64'(done_cnt_a), 64'(exp_done_a));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/coord_request_queue.md
Name: coord_request_queue

Overview:
- Upstream feeder for the cell worker. It walks every pixel of one frame in raster order and computes that pixel's complex-plane start point (x0, y0) from the view parameters.
- Results are buffered in a small FIFO and handed to the cell worker on its rtc_poll_ready / rtc_read handshake.
- Read data is presented one cycle after the read request, which matches the worker's registered poll stage.

Parameters:
- FRAME_W, 320, pixels per row.
- FRAME_H, 240, rows per frame; FRAME_W*FRAME_H must not exceed 131071.
- FIFO_DEPTH, 16, entries buffered; power of two, minimum 2.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latch view parameters and begin a frame
- x_min_in  in  64  x0 of column 0, two's complement fixed point (same format as the escape stepper)
- y_max_in  in  64  y0 of row 0
- step_in  in  64  per-pixel increment in x and y
- rtc_read  in  1  worker pops one entry
- rtc_poll_ready  out  1  FIFO holds at least one entry
- idx_out  out  17  pixel index of the last popped entry
- x0_out  out  64  x0 of the last popped entry
- y0_out  out  64  y0 of the last popped entry
- busy  out  1  frame in progress (generating, or FIFO not yet drained)
- frame_done  out  1  one-cycle pulse on the pop of the last pixel

Behaviour:
- Reset:
  - FSM goes to IDLE; FIFO empties.
  - Outputs: rtc_poll_ready=0, idx_out=17'h1FFFF, x0_out=0, y0_out=0, busy=0, frame_done=0.
  - Reset mid-frame discards all state; no partial output.
- FSM states IDLE, GEN, DRAIN:
  - IDLE, start=1: latch x_min, y_max, step. Set col=0, row=0, idx=0, x_acc=x_min, y_acc=y_max. Go to GEN; busy=1 from the next cycle.
  - GEN: each cycle the FIFO is not full, push {idx, x_acc, y_acc}, then advance.
  - DRAIN: entered after the push of idx=FRAME_W*FRAME_H-1. Go to IDLE when the FIFO is empty and no pop is pending.
  - start in GEN or DRAIN: restart. Flush the FIFO and relatch parameters, exactly as from IDLE. Do not pulse frame_done. The read-data registers keep their values.
- Advance rule:
  - col<FRAME_W-1: col+1, x_acc+=step.
  - Otherwise col=0, x_acc=x_min, row+1, y_acc-=step.
  - idx+1 always.
  - Arithmetic is modulo 2^64; no saturation.
- Push stalls while the FIFO is full; the generator state holds.
- Push and pop in the same cycle are allowed at any occupancy except full-without-pop. Count is unchanged when both occur.
- Read handshake:
  - rtc_poll_ready = (count != 0), registered from the FIFO state.
  - rtc_read=1 while ready in cycle T pops the head. idx_out, x0_out and y0_out are loaded at the end of T and are valid throughout T+1.
  - Outputs hold until the next accepted pop.
- Back-to-back rtc_read on consecutive cycles pops consecutive entries.
- rtc_read while empty is ignored: outputs hold, no underflow.
- An entry pushed in cycle T is visible (rtc_poll_ready=1) in T+1 at the earliest.
- frame_done pulses in T+1 for the pop of the final index, coincident with its data on the outputs. busy falls in the same cycle.
- Ordering: entries leave in strictly increasing idx order within a frame.

Test Plan:
- FRAME_W=4, FRAME_H=3, x_min=-8, y_max=6, step=2; start, with rtc_read held high whenever ready -> 12 entries idx 0..11:
  - idx 0: x0=-8, y0=6
  - idx 3: x0=-2, y0=6
  - idx 4: x0=-8, y0=4
  - idx 11: x0=-2, y0=2
  - frame_done pulses once, with idx 11 on the outputs.
- Same frame with rtc_read held low -> the FIFO fills to FIFO_DEPTH and generation stalls. Then rtc_read is pulsed every 3rd cycle -> no entry lost or duplicated, and idx is contiguous.
- rtc_read asserted while empty, before start -> idx_out stays 17'h1FFFF; rtc_poll_ready stays 0.
- start again mid-frame with x_min=0 -> the next popped entry has idx=0, x0=0. No frame_done for the aborted frame.
- reset_n pulsed low mid-frame -> all outputs return to reset values immediately; a new start produces idx 0 correctly.
- x_min=64'h7FFF_FFFF_FFFF_FFFF, step=1, FRAME_W=2 -> column 1 has x0=64'h8000_0000_0000_0000 (wrap, no saturation).
